// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder that reuses one 4-bit
// carry-lookahead adder over the operands, one nibble per clock, LSB first.
// Operands enter through a valid/ready handshake and the result leaves
// through a second valid/ready handshake.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both high. in_ready is high only in IDLE and
// out_valid only in DONE; both are pure decodes of the state register, so
// neither depends combinationally on in_valid or out_ready. Once out_valid
// is high the result (sum, c_out, ovf) stays stable until the transfer.

// 4-bit carry-lookahead adder: all carries are formed directly from the
// generate/propagate terms and c_in, without rippling through the sum bits.
module cla_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms and flattened lookahead carries.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_in);
        s     = p ^ c[3:0];
        c_out = c[4];
    end

endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    // Number of nibble steps, and the width of the nibble index (min 1 bit).
    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   a_q,       a_d;
    logic [WIDTH-1:0]   b_q,       b_d;
    logic               carry_q,   carry_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [WIDTH-1:0]   sum_q,     sum_d;
    logic               c_out_q,   c_out_d;
    logic               ovf_q,     ovf_d;

    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic [3:0]         add_s;
    logic               add_c;
    logic               last_step;
    logic               msb_carry_in;

    // Select the current operand nibbles; the loop keeps every part-select
    // constant so the mux is a plain decode of idx_q.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    cla_adder_4bit u_cla (
        .a     (nib_a),
        .b     (nib_b),
        .c_in  (carry_q),
        .s     (add_s),
        .c_out (add_c)
    );

    // Step-control decodes: final nibble, and the carry into bit WIDTH-1
    // recovered from the MSB sum bit (only meaningful on the final step,
    // when the top nibble is the one in the adder).
    always_comb begin
        last_step    = (idx_q == IDX_W'(N - 1));
        msb_carry_in = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ add_s[3];
    end

    // Next-state and datapath update; every register holds by default.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[4*i +: 4] = add_s;
                    end
                end
                carry_d = add_c;
                if (last_step) begin
                    c_out_d = add_c;
                    ovf_d   = msb_carry_in ^ add_c;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags decode the state register; results come straight
    // from their registers.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        sum       = sum_q;
        c_out     = c_out_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16): directed vector table, hand-written
// backpressure and mid-operation reset sequences, then a random stream
// against an arithmetic reference model.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int N     = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [WIDTH+1:0] exp_q[$];

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    vec_t vecs[10];

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and hold in_valid until the accept edge has passed.
    task automatic accept(input string name, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic cv);
        int n;
        a        = av;
        b        = bv;
        c_in     = cv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({name, "_ready_before"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        c_in     = 1'($urandom_range(0, 1));
        check({name, "_ready_drop"}, in_ready, 0);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        out_ready = 1'b1;
        accept(name, v.a, v.b, v.cin);
        wait_done(lat);
        check({name, "_latency"}, lat, N);
        check({name, "_sum"}, sum, v.sum);
        check({name, "_cout"}, c_out, v.cout);
        check({name, "_ovf"}, ovf, v.ovf);
        tick();
        check({name, "_valid_after_hs"}, out_valid, 0);
        check({name, "_ready_after_hs"}, in_ready, 1);
    endtask

    // Random-stream driver: random idle gaps, random operands.
    task automatic rnd_driver();
        int               last_acc;
        int               n;
        logic [WIDTH-1:0] av, bv;
        logic             cv;
        logic [WIDTH:0]   s17;
        logic             ov;
        last_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            av = WIDTH'($urandom);
            bv = WIDTH'($urandom);
            cv = 1'($urandom_range(0, 1));
            a = av;
            b = bv;
            c_in = cv;
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) begin
                check("rnd_accept_wait", in_ready, 1);
                in_valid = 1'b0;
                break;
            end
            tick();
            in_valid = 1'b0;
            s17 = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
            ov  = (av[WIDTH-1] == bv[WIDTH-1]) && (s17[WIDTH-1] != av[WIDTH-1]);
            exp_q.push_back({ov, s17});
            if (i > 0) check("rnd_interval_ge", (cyc - last_acc) >= N + 2, 1);
            last_acc = cyc;
        end
    endtask

    // Random-stream monitor with random out_ready; each transfer pops one expectation.
    task automatic rnd_monitor();
        int               got;
        int               idle;
        logic [WIDTH+1:0] e;
        got  = 0;
        idle = 0;
        while (got < 1000 && idle < 2000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_result", {ovf, c_out, sum}, e);
                end
                got++;
                idle = 0;
            end else begin
                idle++;
            end
            tick();
        end
        check("rnd_result_count", got, 1000);
    endtask

    initial begin
        int lat;

        vecs[0] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[8] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
        vecs[9] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};

        // Reset
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", c_out, 0);
        check("rst_ovf", ovf, 0);

        // Directed vector table
        for (int k = 0; k < 10; k++) begin
            run_vec($sformatf("vec%0d", k), vecs[k]);
        end

        // Backpressure: hold DONE while new operands are pending
        out_ready = 1'b0;
        accept("bp", 16'h1111, 16'h2222, 1'b0);
        wait_done(lat);
        check("bp_latency", lat, N);
        a        = 16'h0101;
        b        = 16'h0202;
        c_in     = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_sum", sum, 16'h3333);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_hs_valid", out_valid, 0);
        check("bp_hs_ready", in_ready, 1);
        check("bp_hs_sum_kept", sum, 16'h3333);
        tick();
        in_valid = 1'b0;
        check("bp_pending_accepted", in_ready, 0);
        wait_done(lat);
        check("bp_pending_latency", lat, N);
        check("bp_pending_sum", sum, 16'h0303);
        tick();

        // Reset mid-RUN at idx=2
        accept("mid", 16'h1234, 16'h1111, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", c_out, 0);
        check("mid_rst_ovf", ovf, 0);
        #3 rst_n = 1'b1;
        repeat (5) tick();
        check("mid_no_result", out_valid, 0);
        run_vec("post_rst", vecs[5]);

        // Random stream
        fork
            rnd_driver();
            rnd_monitor();
        join
        check("rnd_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
